// File: rtl/pss_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pss_pkg
// Purpose  : Shared definitions for the multi-sequence PSS correlator:
//            controller state encoding and full-precision width helpers.
// Revision : 1.0 - initial release
// ============================================================================
package pss_pkg;

  // Correlator controller states, explicitly encoded on two bits
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUM  = 2'd1,
    ST_MAG  = 2'd2,
    ST_OUT  = 2'd3
  } pss_state_e;

  // Width of one correlation component: one complex product plus the growth
  // from accumulating pss_len terms, with no truncation anywhere.
  function automatic int sum_width(input int in_dw, input int tap_dw, input int pss_len);
    return in_dw / 2 + tap_dw + $clog2(pss_len) + 1;
  endfunction

  // Width that holds re^2 + im^2 of two sum_width components exactly.
  function automatic int mag_width(input int in_dw, input int tap_dw, input int pss_len);
    return 2 * sum_width(in_dw, tap_dw, pss_len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/complex_mag_sq.sv
`default_nettype none
// ============================================================================
// Module   : complex_mag_sq
// Purpose  : Registered |z|^2 of a complex value, saturated to OUT_DW bits.
// Revision : 1.0 - initial release
// ============================================================================
module complex_mag_sq #(
  parameter int SUM_W  = 40,
  parameter int OUT_DW = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic signed [SUM_W-1:0] i_re,
  input  logic signed [SUM_W-1:0] i_im,
  output logic [OUT_DW-1:0]       o_mag
);

  localparam int MAG_W = 2 * SUM_W;

  logic signed [MAG_W-1:0] w_re_ext;
  logic signed [MAG_W-1:0] w_im_ext;
  logic        [MAG_W-1:0] w_mag_full;
  logic        [OUT_DW-1:0] w_mag_sat;
  logic        [OUT_DW-1:0] r_mag;

  // Each square is non-negative and the sum peaks at 2^(MAG_W-1), so the
  // result fits MAG_W bits when read as unsigned.
  assign w_re_ext   = MAG_W'(i_re);
  assign w_im_ext   = MAG_W'(i_im);
  assign w_mag_full = $unsigned(w_re_ext * w_re_ext) + $unsigned(w_im_ext * w_im_ext);

  if (MAG_W > OUT_DW) begin : g_sat
    assign w_mag_sat = (|w_mag_full[MAG_W-1:OUT_DW]) ? {OUT_DW{1'b1}} : w_mag_full[OUT_DW-1:0];
  end else begin : g_nosat
    assign w_mag_sat = OUT_DW'(w_mag_full);
  end

  // Capture the saturated magnitude when the controller is in its MAG step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag <= '0;
    end else if (i_en) begin
      r_mag <= w_mag_sat;
    end
  end

  assign o_mag = r_mag;

endmodule
`default_nettype wire

// File: rtl/pss_correlator_mc.sv
`default_nettype none
// ============================================================================
// Module   : pss_correlator_mc
// Purpose  : Correlates each accepted complex sample history against N_SEQ
//            reference sequences and streams one |corr|^2 beat per sequence.
// Revision : 1.0 - initial release
// ============================================================================
module pss_correlator_mc
  import pss_pkg::*;
#(
  parameter int IN_DW   = 32,
  parameter int TAP_DW  = 16,
  parameter int PSS_LEN = 127,
  parameter int N_SEQ   = 3,
  parameter int OUT_DW  = 48,
  parameter logic [N_SEQ*PSS_LEN*2*TAP_DW-1:0] PSS_LOCAL = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [IN_DW-1:0]  s_axis_in_tdata,
  input  logic              s_axis_in_tvalid,
  output logic              s_axis_in_tready,
  input  logic [OUT_DW-1:0] threshold_i,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic [1:0]        m_axis_out_tuser,
  output logic              m_axis_out_tlast,
  output logic              m_axis_out_tvalid,
  input  logic              m_axis_out_tready,
  output logic              peak_o
);

  localparam int         HALF_W = IN_DW / 2;
  localparam int         SUM_W  = sum_width(IN_DW, TAP_DW, PSS_LEN);
  localparam logic [1:0] LAST_K = 2'(N_SEQ - 1);

  pss_state_e              r_state;
  logic [1:0]              r_k;
  logic [IN_DW-1:0]        r_dl [PSS_LEN];
  logic signed [SUM_W-1:0] r_sum_re;
  logic signed [SUM_W-1:0] r_sum_im;
  logic                    r_tvalid;
  logic [1:0]              r_tuser;
  logic                    r_tlast;

  logic                    w_in_hs;
  logic                    w_out_hs;
  logic [OUT_DW-1:0]       w_mag;
  logic signed [SUM_W-1:0] w_acc_re;
  logic signed [SUM_W-1:0] w_acc_im;
  logic signed [SUM_W-1:0] w_x_re;
  logic signed [SUM_W-1:0] w_x_im;
  logic signed [SUM_W-1:0] w_t_re;
  logic signed [SUM_W-1:0] w_t_im;
  int                      w_base;

  assign s_axis_in_tready = (r_state == ST_IDLE);
  assign w_in_hs          = s_axis_in_tvalid && s_axis_in_tready;
  assign w_out_hs         = r_tvalid && m_axis_out_tready;

  // Controller: accept a sample, then SUM -> MAG -> OUT once per sequence
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= ST_IDLE;
      r_k      <= '0;
      r_tvalid <= 1'b0;
      r_tuser  <= '0;
      r_tlast  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_in_hs) begin
            r_k     <= '0;
            r_state <= ST_SUM;
          end
        end
        ST_SUM: r_state <= ST_MAG;
        ST_MAG: begin
          r_tvalid <= 1'b1;
          r_tuser  <= r_k;
          r_tlast  <= (r_k == LAST_K);
          r_state  <= ST_OUT;
        end
        ST_OUT: begin
          if (w_out_hs) begin
            r_tvalid <= 1'b0;
            if (r_k == LAST_K) begin
              r_state <= ST_IDLE;
            end else begin
              r_k     <= r_k + 2'd1;
              r_state <= ST_SUM;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sample delay line, newest in slot 0; cleared slots act as zero history
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < PSS_LEN; i++) r_dl[i] <= '0;
    end else if (w_in_hs) begin
      r_dl[0] <= s_axis_in_tdata;
      for (int i = 1; i < PSS_LEN; i++) r_dl[i] <= r_dl[i-1];
    end
  end

  // Full-precision complex dot product of the history with sequence r_k
  always_comb begin
    w_acc_re = '0;
    w_acc_im = '0;
    w_x_re   = '0;
    w_x_im   = '0;
    w_t_re   = '0;
    w_t_im   = '0;
    w_base   = 0;
    for (int i = 0; i < PSS_LEN; i++) begin
      w_base   = (int'(r_k) * PSS_LEN + i) * 2 * TAP_DW;
      w_x_re   = SUM_W'($signed(r_dl[i][HALF_W-1:0]));
      w_x_im   = SUM_W'($signed(r_dl[i][IN_DW-1:HALF_W]));
      w_t_re   = SUM_W'($signed(PSS_LOCAL[w_base +: TAP_DW]));
      w_t_im   = SUM_W'($signed(PSS_LOCAL[w_base + TAP_DW +: TAP_DW]));
      w_acc_re = w_acc_re + w_x_re * w_t_re - w_x_im * w_t_im;
      w_acc_im = w_acc_im + w_x_re * w_t_im + w_x_im * w_t_re;
    end
  end

  // Latch the correlation sums during the SUM step
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sum_re <= '0;
      r_sum_im <= '0;
    end else if (r_state == ST_SUM) begin
      r_sum_re <= w_acc_re;
      r_sum_im <= w_acc_im;
    end
  end

  complex_mag_sq #(
    .SUM_W  (SUM_W),
    .OUT_DW (OUT_DW)
  ) u_mag (
    .clk   (clk_i),
    .rst   (reset_i),
    .i_en  (r_state == ST_MAG),
    .i_re  (r_sum_re),
    .i_im  (r_sum_im),
    .o_mag (w_mag)
  );

  assign m_axis_out_tdata  = w_mag;
  assign m_axis_out_tuser  = r_tuser;
  assign m_axis_out_tlast  = r_tlast;
  assign m_axis_out_tvalid = r_tvalid;
  // Peak flag lives only in the handshake cycle of a qualifying beat
  assign peak_o            = w_out_hs && (w_mag >= threshold_i);

endmodule
`default_nettype wire
